// File: rtl/gate_logic_array.sv
// Multi-channel toggle gate: per-period fire budget with deferred replay.
// Ports: clk, rst_n, logic_reset, in, en -> out, exhausted, pend_ovf, busy.
module gate_logic_array #(
   parameter int CHANNELS   = 8,
   parameter int MAX_FIRES  = 1,
   parameter int PEND_DEPTH = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                logic_reset,
   input  logic [CHANNELS-1:0] in,
   input  logic [CHANNELS-1:0] en,
   output logic [CHANNELS-1:0] out,
   output logic [CHANNELS-1:0] exhausted,
   output logic [CHANNELS-1:0] pend_ovf,
   output logic                busy
);

   localparam int CW = $clog2(MAX_FIRES + 1);

   logic [CHANNELS-1:0] pend_nz;
   logic [CHANNELS-1:0] pend_nz_nxt;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic          prev_q;
      logic          out_q;
      logic          exh_q;
      logic [CW-1:0] cnt;
      logic [CW-1:0] c_eff;
      logic [CW-1:0] c_nxt;
      logic          t;
      logic          budget;
      logic          fire;

      assign t      = en[g] & (prev_q ^ in[g]);
      // The strobe cycle already belongs to the new period.
      assign c_eff  = logic_reset ? '0 : cnt;
      assign budget = (c_eff < CW'(MAX_FIRES));
      assign fire   = en[g] & budget & (t | pend_nz[g]);
      // Cannot wrap: fire only when c_eff < MAX_FIRES.
      assign c_nxt  = c_eff + CW'(fire);

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            prev_q <= in[g];
            out_q  <= 1'b0;
            exh_q  <= 1'b0;
            cnt    <= '0;
         end else begin
            prev_q <= in[g];
            out_q  <= fire;
            exh_q  <= (c_nxt == CW'(MAX_FIRES));
            cnt    <= c_nxt;
         end
      end

      assign out[g]       = out_q;
      assign exhausted[g] = exh_q;

      if (PEND_DEPTH > 0) begin : g_pend
         localparam int PW  = $clog2(PEND_DEPTH + 1);
         localparam int PW1 = PW + 1;

         logic [PW-1:0] pend;
         logic [PW-1:0] pend_n;
         logic [PW1-1:0] pend_sum;
         logic          ovf;
         logic          ovf_q;

         // Never negative: fire with pend==0 implies t.
         assign pend_sum = {1'b0, pend} + PW1'(t) - PW1'(fire);
         assign ovf      = (pend_sum > PW1'(PEND_DEPTH));
         assign pend_n   = ovf ? PW'(PEND_DEPTH) : pend_sum[PW-1:0];

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               pend  <= '0;
               ovf_q <= 1'b0;
            end else begin
               pend <= pend_n;
               if (ovf) ovf_q <= 1'b1;
            end
         end

         assign pend_nz[g]     = |pend;
         assign pend_nz_nxt[g] = |pend_n;
         assign pend_ovf[g]    = ovf_q;
      end else begin : g_nopend
         // No store: excess toggles vanish without a flag.
         assign pend_nz[g]     = 1'b0;
         assign pend_nz_nxt[g] = 1'b0;
         assign pend_ovf[g]    = 1'b0;
      end
   end

   // Registered from next-state pend so it tracks the pend registers.
   always_ff @(posedge clk) begin
      if (!rst_n) busy <= 1'b0;
      else        busy <= |pend_nz_nxt;
   end

endmodule

// File: tb/tb_gate_logic_array.sv
// Directed bench for gate_logic_array: default instance plus a
// MAX_FIRES=3 / PEND_DEPTH=0 instance.
module tb_gate_logic_array;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       a_lr, b_lr;
   logic [7:0] a_in, a_en, b_in, b_en;
   logic [7:0] a_out, a_exh, a_ovf;
   logic [7:0] b_out, b_exh, b_ovf;
   logic       a_busy, b_busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   gate_logic_array #(
      .CHANNELS(8), .MAX_FIRES(1), .PEND_DEPTH(3)
   ) u_a (
      .clk(clk), .rst_n(rst_n), .logic_reset(a_lr),
      .in(a_in), .en(a_en), .out(a_out),
      .exhausted(a_exh), .pend_ovf(a_ovf), .busy(a_busy)
   );

   gate_logic_array #(
      .CHANNELS(8), .MAX_FIRES(3), .PEND_DEPTH(0)
   ) u_b (
      .clk(clk), .rst_n(rst_n), .logic_reset(b_lr),
      .in(b_in), .en(b_en), .out(b_out),
      .exhausted(b_exh), .pend_ovf(b_ovf), .busy(b_busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      a_in = 8'h00; a_en = 8'hFF; a_lr = 1'b0;
      b_in = 8'h00; b_en = 8'hFF; b_lr = 1'b0;
      tick(); tick();
      chk("rst_a_out", a_out, 8'h00);
      chk("rst_a_exh", a_exh, 8'h00);
      chk("rst_a_ovf", a_ovf, 8'h00);
      chk("rst_a_busy", a_busy, 1'b0);
      chk("rst_b_out", b_out, 8'h00);
      chk("rst_b_exh", b_exh, 8'h00);
      rst_n = 1'b1;
      tick(); tick();
      chk("rel_a_out", a_out, 8'h00);

      // basic edge
      a_in[0] = 1'b1;
      tick();
      chk("edge_out", a_out, 8'h01);
      chk("edge_exh", a_exh, 8'h01);
      tick();
      chk("edge_out_once", a_out, 8'h00);
      chk("edge_exh_hold", a_exh, 8'h01);
      a_in[0] = 1'b0;
      tick();
      chk("defer_out", a_out, 8'h00);
      chk("defer_busy", a_busy, 1'b1);
      tick();
      chk("defer_busy2", a_busy, 1'b1);

      // replay on period boundary
      a_lr = 1'b1;
      tick();
      chk("replay_out", a_out, 8'h01);
      chk("replay_busy", a_busy, 1'b0);
      chk("replay_exh", a_exh, 8'h01);
      a_lr = 1'b0;
      tick();
      chk("replay_done", a_out, 8'h00);

      // fresh toggle plus pending entry on strobe cycle
      a_in[0] = 1'b1;
      tick();
      chk("sim_pend_out", a_out, 8'h00);
      chk("sim_pend_busy", a_busy, 1'b1);
      a_in[0] = 1'b0;
      a_lr = 1'b1;
      tick();
      chk("sim_out", a_out, 8'h01);
      chk("sim_busy", a_busy, 1'b1);
      a_lr = 1'b0;
      tick();
      chk("sim_single", a_out, 8'h00);
      chk("sim_busy_hold", a_busy, 1'b1);
      a_lr = 1'b1;
      tick();
      chk("sim_replay", a_out, 8'h01);
      chk("sim_drain", a_busy, 1'b0);
      a_lr = 1'b0;
      tick();

      // multi-fire, no pend store
      for (int i = 0; i < 6; i++) begin
         b_in[2] = ~b_in[2];
         tick();
         chk("mf_out", b_out, (i < 3) ? 8'h04 : 8'h00);
         chk("mf_exh", b_exh, (i >= 2) ? 8'h04 : 8'h00);
      end
      chk("mf_ovf", b_ovf, 8'h00);
      chk("mf_busy", b_busy, 1'b0);

      // overflow on channel 4
      a_in[4] = 1'b1;
      tick();
      chk("ov_fire", a_out, 8'h10);
      chk("ov_exh", a_exh, 8'h11);
      for (int i = 0; i < 5; i++) begin
         a_in[4] = ~a_in[4];
         tick();
         chk("ov_out", a_out, 8'h00);
         chk("ov_flag", a_ovf, (i >= 3) ? 8'h10 : 8'h00);
      end
      chk("ov_busy", a_busy, 1'b1);
      for (int r = 0; r < 3; r++) begin
         a_lr = 1'b1;
         tick();
         chk("ovr_out", a_out, 8'h10);
         chk("ovr_exh", a_exh, 8'h10);
         chk("ovr_busy", a_busy, (r < 2) ? 1'b1 : 1'b0);
         a_lr = 1'b0;
         tick(); tick();
         chk("ovr_gap", a_out, 8'h00);
         chk("ovr_sticky", a_ovf, 8'h10);
      end
      a_lr = 1'b1;
      tick();
      chk("ovr_empty", a_out, 8'h00);
      chk("ovr_idle", a_busy, 1'b0);
      a_lr = 1'b0;
      tick();

      // masked channel
      a_en[1] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a_in[1] = ~a_in[1];
         tick();
         chk("mask_out", a_out, 8'h00);
      end
      a_en[1] = 1'b1;
      tick();
      chk("mask_reen", a_out, 8'h00);
      chk("mask_busy", a_busy, 1'b0);

      // reset mid-operation with pending entries
      a_in = 8'h09;
      tick();
      chk("mid_fire", a_out, 8'h09);
      a_in = 8'h00;
      tick();
      chk("mid_p1", a_out, 8'h00);
      a_in = 8'h09;
      tick();
      chk("mid_p2", a_out, 8'h00);
      chk("mid_busy", a_busy, 1'b1);
      rst_n = 1'b0;
      a_in = 8'hA5;
      tick();
      chk("mid_rst_out", a_out, 8'h00);
      chk("mid_rst_exh", a_exh, 8'h00);
      chk("mid_rst_ovf", a_ovf, 8'h00);
      chk("mid_rst_busy", a_busy, 1'b0);
      rst_n = 1'b1;
      tick(); tick();
      chk("mid_rel_out", a_out, 8'h00);
      chk("mid_rel_busy", a_busy, 1'b0);
      a_lr = 1'b1;
      tick();
      chk("mid_no_replay", a_out, 8'h00);
      a_lr = 1'b0;
      a_in[0] = 1'b0;
      tick();
      chk("mid_fresh", a_out, 8'h01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gate_logic_array.md
Name: gate_logic_array

Overview:
- Multi-channel, parametrised successor to the single-shot toggle gate.
- Each channel detects input toggles and emits registered one-cycle output pulses, up to MAX_FIRES pulses per logic period. A logic period is delimited by logic_reset.
- Toggles that arrive after a channel's budget is spent can be deferred and replayed in later periods, up to PEND_DEPTH per channel.
- Sits between wire-net state sampling and the lamp/gate evaluation stage of the logic simulator.

Parameters:
- CHANNELS, 8, number of independent gate channels (>=1).
- MAX_FIRES, 1, output pulses allowed per channel per logic period (>=1).
- PEND_DEPTH, 3, deferred toggles stored per channel (>=0). 0 = excess toggles are dropped.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- logic_reset  in  1  logic-period boundary strobe.
- in  in  CHANNELS  per-channel wire state.
- en  in  CHANNELS  per-channel enable.
- out  out  CHANNELS  registered fire pulse.
- exhausted  out  CHANNELS  registered; channel budget spent this period.
- pend_ovf  out  CHANNELS  sticky; a toggle was lost to a full pending store.
- busy  out  1  registered; OR over channels of (pend != 0).

Behaviour:
- Reset: rst_n low at a posedge sets out=0, exhausted=0, pend_ovf=0, busy=0, and cnt=0 and pend=0 for every channel. It also loads prev_in<=in, so releasing reset produces no spurious toggle. Reset overrides logic_reset and all other inputs; asserting it mid-operation discards pending toggles.
- Widths: cnt is clog2(MAX_FIRES+1) bits; pend is clog2(PEND_DEPTH+1) bits, with no pend register when PEND_DEPTH=0.
- Per channel, per cycle (not in reset):
  - t = en & (prev_in ^ in).
  - prev_in <= in unconditionally, including when en=0.
  - c_eff = logic_reset ? 0 : cnt. The logic_reset cycle is the first cycle of the new period.
  - budget = (c_eff < MAX_FIRES).
  - fire = en & budget & (t | pend!=0).
  - out <= fire. Latency is 1 cycle from the in edge to the out pulse. At most one pulse per channel per cycle.
  - cnt <= c_eff + fire.
  - exhausted <= (c_eff + fire == MAX_FIRES).
  - pend_next = pend + t - fire.
    - If pend_next > PEND_DEPTH: pend <= PEND_DEPTH and pend_ovf <= 1.
    - pend_ovf is cleared only by rst_n.
  - With PEND_DEPTH=0, excess toggles are dropped silently and pend_ovf stays 0.
- Replay: a pending entry fires on the first cycle where the channel is enabled and has budget, one per cycle.
  - A new toggle and a pending entry in the same cycle produce one pulse; net pend is unchanged.
- Disabled channel (en=0): no fire, toggles are not pended, pend and cnt are held. logic_reset still clears cnt.
- Channels are fully independent; busy is derived from registered pend (next-state value).
- Toggle lost to a full store: a toggle that arrives with no budget and pend==PEND_DEPTH sets pend_ovf and leaves pend at PEND_DEPTH.

Test Plan:
- Basic edge: CHANNELS=8, MAX_FIRES=1, en=FF, rst_n released with in=00. in[0] 0->1 at cycle 5 -> out[0]=1 in cycle 6 only, exhausted[0]=1 from cycle 6. in[0] 1->0 at cycle 8 -> no pulse, pend[0]=1, busy=1.
- Replay: continue the previous scenario, logic_reset pulsed at cycle 10 -> out[0]=1 in cycle 11, pend[0]=0, busy=0, exhausted[0]=1. logic_reset cycle with a simultaneous fresh toggle -> exactly one pulse, pend unchanged.
- Multi-fire: MAX_FIRES=3, PEND_DEPTH=0, in[2] toggled every cycle for 6 cycles in one period -> out[2] high for exactly 3 consecutive cycles, exhausted[2]=1 after the third, pend_ovf[2]=0.
- Overflow: MAX_FIRES=1, PEND_DEPTH=3, channel 4 fires once then receives 5 more toggles -> pend[4] saturates at 3, pend_ovf[4]=1. Three logic_resets spaced apart -> one replay pulse each. pend_ovf stays 1 until rst_n low.
- Enable/mask: en[1]=0 while in[1] toggles 4 times, then en[1]=1 -> no out[1] pulses, pend[1]=0, no spurious pulse on re-enable.
- Reset mid-op: pend=2 on channels 0 and 3, in=A5 held, rst_n low for one cycle -> all outputs 0 the next cycle, busy=0, no pulses after release with in unchanged.
